sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Serial-in parallel-out receiver. It is the receiving end of the PISO shift-register link: it collects WIDTH serial bits, MSB first, into a shift register. Each completed word is presented on a registered parallel output with a valid/ready handshake. The block sits between the serial link pins and the parallel consumer, and flags framing errors and overruns.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden

Ports:
CLK  input  1  single clock; all logic on the rising edge
RST  input  1  synchronous, active-high reset
SIN  input  1  serial data bit
SIN_VALID  input  1  SIN is sampled on this edge
SIN_FRAME  input  1  qualified by SIN_VALID; marks the current bit as the first (MSB) bit of a word
PDATA  output  WIDTH  received word; held stable while PVALID=1
PVALID  output  1  PDATA holds an unconsumed word
PREADY  input  1  consumer accepts PDATA when PVALID&PREADY
FRAME_ERR  output  1  one-cycle pulse: word aborted by an early SIN_FRAME
OVERRUN  output  1  one-cycle pulse: completed word dropped because the output was full
BUSY  output  1  high while a word is partially received

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, counter=0, shift register=0, PDATA=0, PVALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
- Reset mid-word discards the partial word. Reset also discards any word pending on PDATA.
- Every bit is sampled only when SIN_VALID=1. Cycles with SIN_VALID=0 stall the receiver with no state change; gaps of any length are legal.
- IDLE:
  - SIN_VALID&SIN_FRAME: shift in SIN, counter=1, go to SHIFT.
  - SIN_VALID without SIN_FRAME: bit ignored; no error is raised.
- SHIFT:
  - Each valid bit: shift reg <= {shift reg[WIDTH-2:0], SIN}, counter += 1.
  - When the valid bit brings the counter to WIDTH, the word is complete. Go to IDLE (or to PARITY if the optional feature is enabled).
- SIN_FRAME while in SHIFT: the partial word is aborted and FRAME_ERR pulses for 1 cycle. The current bit becomes bit 1 of a new word (counter=1, stay in SHIFT).
- Word completion and output handoff:
  - If PVALID=0, or PVALID&PREADY in the same cycle, load PDATA and set PVALID=1 on the next edge.
  - Latency: PVALID rises the cycle after the last bit is sampled.
  - Otherwise the new word is dropped, PDATA is kept unchanged, and OVERRUN pulses for 1 cycle.
- PVALID&PREADY with no completing word: PVALID=0 on the next edge. PDATA keeps its last value.
- BUSY=1 in SHIFT and PARITY, 0 in IDLE.
- Back-to-back words are supported: a SIN_FRAME bit may arrive on the cycle immediately after a completing bit.
- The counter never wraps; it is reset to 1 or returned to IDLE on completion.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - After bit WIDTH, the FSM enters PARITY and the next valid bit is the parity bit. The word is then delivered per the handoff rules.
  - Adds output PERR (1 bit), loaded alongside PDATA. PERR=1 when the XOR of the data bits and the parity bit is 1 (even parity violated). Reset value 0.
  - SIN_FRAME during PARITY acts as in SHIFT: FRAME_ERR pulses, the word is aborted and a new word starts.
- Not defined: the PARITY state and the PERR port do not exist; the FSM goes straight to IDLE on completion.

Decomposition:
- Package sipo_pkg holds:
  - the state enum: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2;
  - the localparam width helper for CNT_W.
- One sub-module, sipo_out_reg: the PDATA/PVALID holding register with the handshake and overrun detection. The shift/FSM logic stays in the top.

Test Plan:
- Basic word, WIDTH=8, PREADY=1: 8 back-to-back valid bits 1,0,1,0,0,1,0,1 with FRAME on the first → PDATA=8'hA5 and PVALID=1 exactly 1 cycle after the 8th bit. FRAME_ERR=0, OVERRUN=0.
- Stall tolerance: same word with SIN_VALID=0 gaps of 0..5 cycles randomly inserted → PDATA=8'hA5. BUSY stays 1 from the first bit until completion.
- Framing abort: 3 bits of one word, then FRAME with bits of 8'h3C → FRAME_ERR pulses once; the only word delivered is 8'h3C.
- Overrun: PREADY=0, send 8'h11 then 8'h22 → PDATA stays 8'h11, OVERRUN pulses once after the 8th bit of 8'h22. Next, PREADY=1 for 1 cycle → PVALID falls.
- Simultaneous accept and complete: PVALID=1 with 8'h11, PREADY=1 on the same cycle 8'h22 completes → PDATA=8'h22 and PVALID stays 1, no OVERRUN.
- Reset mid-word, plus parity (with SIPO_PARITY_EN):
  - RST after 4 bits → all outputs 0. A fresh 8'hA5 then decodes correctly.
  - Parity bit 0 for 8'hA5 → PERR=0.
  - Parity bit 1 for 8'hA5 → PERR=1.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the SIPO deserializer.
// The PARITY state is only reached when SIPO_PARITY_EN is defined.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial link input and parallel output handshake bundle.
// PERR exists only when SIPO_PARITY_EN is defined.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             SIN;
    logic             SIN_VALID;
    logic             SIN_FRAME;
    logic [WIDTH-1:0] PDATA;
    logic             PVALID;
    logic             PREADY;
    logic             FRAME_ERR;
    logic             OVERRUN;
    logic             BUSY;
`ifdef SIPO_PARITY_EN
    logic             PERR;
`endif

    modport master (
        output SIN, SIN_VALID, SIN_FRAME, PREADY,
`ifdef SIPO_PARITY_EN
        input  PERR,
`endif
        input  PDATA, PVALID, FRAME_ERR, OVERRUN, BUSY
    );

    modport slave (
        input  SIN, SIN_VALID, SIN_FRAME, PREADY,
`ifdef SIPO_PARITY_EN
        output PERR,
`endif
        output PDATA, PVALID, FRAME_ERR, OVERRUN, BUSY
    );

endinterface

// File: rtl/sipo_deserializer_out_reg.sv
// Parallel output holding register: valid/ready handoff and overrun detection.
// Carries the parity error flag alongside the data when SIPO_PARITY_EN is defined.
module sipo_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
`ifdef SIPO_PARITY_EN
    input  logic             i_perr,
    output logic             o_perr,
`endif
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
`ifdef SIPO_PARITY_EN
    logic             r_perr;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A word may land in the same cycle the pending one is consumed.
                if (!r_valid || i_ready) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    r_perr  <= i_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
`ifdef SIPO_PARITY_EN
    assign o_perr    = r_perr;
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver, MSB first, with framing-error flag.
// Defining SIPO_PARITY_EN adds a trailing even-parity bit and the PERR output.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input logic CLK,
    input logic RST,
    sipo_deserializer_if.slave bus
);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [WIDTH-1:0] r_shift, w_next_shift;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_word;
    logic             w_word_done;
    logic             w_frame_err;
    logic             r_frame_err;
    logic             w_perr;

    assign w_shifted = {r_shift[WIDTH-2:0], bus.SIN};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_shift     <= w_next_shift;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_shift = r_shift;
        w_word       = w_shifted;
        w_word_done  = 1'b0;
        w_frame_err  = 1'b0;
        w_perr       = 1'b0;
        if (bus.SIN_VALID) begin
            case (r_state)
                IDLE: begin
                    if (bus.SIN_FRAME) begin
                        w_next_shift = w_shifted;
                        w_next_cnt   = CNT_W'(1);
                        w_next_state = SHIFT;
                    end
                end
                SHIFT: begin
                    w_next_shift = w_shifted;
                    if (bus.SIN_FRAME) begin
                        w_frame_err = 1'b1;
                        w_next_cnt  = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                        w_next_cnt   = CNT_W'(WIDTH);
                        w_next_state = PARITY;
`else
                        w_word_done  = 1'b1;
                        w_next_cnt   = '0;
                        w_next_state = IDLE;
`endif
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (bus.SIN_FRAME) begin
                        w_frame_err  = 1'b1;
                        w_next_shift = w_shifted;
                        w_next_cnt   = CNT_W'(1);
                        w_next_state = SHIFT;
                    end else begin
                        w_word       = r_shift;
                        w_perr       = (^r_shift) ^ bus.SIN;
                        w_word_done  = 1'b1;
                        w_next_cnt   = '0;
                        w_next_state = IDLE;
                    end
                end
`endif
                default: begin
                    w_next_cnt   = '0;
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (w_word_done),
        .i_data    (w_word),
        .i_ready   (bus.PREADY),
`ifdef SIPO_PARITY_EN
        .i_perr    (w_perr),
        .o_perr    (bus.PERR),
`endif
        .o_data    (bus.PDATA),
        .o_valid   (bus.PVALID),
        .o_overrun (bus.OVERRUN)
    );

`ifndef SIPO_PARITY_EN
    logic w_unused;
    assign w_unused = w_perr;
`endif

    assign bus.FRAME_ERR = r_frame_err;
    assign bus.BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=8); parity steps need SIPO_PARITY_EN.
module tb_sipo_deserializer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sipo_deserializer_if #(.WIDTH(8)) bus ();

    sipo_deserializer #(.WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    logic idle_ready = 1'b1;
    logic busy_bad   = 1'b0;
    int   ferr_cnt   = 0;
    int   ovr_cnt    = 0;
    int   deliv_cnt  = 0;
    logic [7:0] last_word = 8'h00;

    // Event counters sampled with pre-edge values.
    always @(posedge CLK) begin
        if (!RST) begin
            if (bus.FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
            if (bus.OVERRUN)   ovr_cnt  <= ovr_cnt + 1;
            if (bus.PVALID && bus.PREADY) begin
                deliv_cnt <= deliv_cnt + 1;
                last_word <= bus.PDATA;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        bus.SIN_VALID = 1'b0;
        bus.SIN_FRAME = 1'b0;
        bus.PREADY    = idle_ready;
    endtask

    task automatic clear_counts();
        @(negedge CLK);
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        deliv_cnt = 0;
        bus.SIN_VALID = 1'b0;
        bus.SIN_FRAME = 1'b0;
        bus.PREADY    = idle_ready;
    endtask

    task automatic drive_bit(input logic b, input logic f, input logic rdy);
        @(negedge CLK);
        bus.SIN       = b;
        bus.SIN_VALID = 1'b1;
        bus.SIN_FRAME = f;
        bus.PREADY    = rdy;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++)
            drive_bit(w[7-i], (i == 0), idle_ready);
    endtask

    // Sends one full word (plus parity bit when enabled); last_ready raises
    // PREADY only on the final sampled bit.
    task automatic send_word(input logic [7:0] w, input int maxgap,
                             input logic last_ready, input logic par_flip);
        logic rdy;
        for (int i = 7; i >= 0; i--) begin
            if (i < 7) begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(negedge CLK);
                    if (!bus.BUSY) busy_bad = 1'b1;
                    bus.SIN_VALID = 1'b0;
                    bus.SIN_FRAME = 1'b0;
                    bus.PREADY    = idle_ready;
                end
            end
`ifdef SIPO_PARITY_EN
            rdy = idle_ready;
`else
            rdy = (i == 0 && last_ready) ? 1'b1 : idle_ready;
`endif
            @(negedge CLK);
            if (i < 7 && !bus.BUSY) busy_bad = 1'b1;
            bus.SIN       = w[i];
            bus.SIN_VALID = 1'b1;
            bus.SIN_FRAME = (i == 7);
            bus.PREADY    = rdy;
        end
`ifdef SIPO_PARITY_EN
        drive_bit((^w) ^ par_flip, 1'b0, last_ready ? 1'b1 : idle_ready);
`else
        if (par_flip) busy_bad = busy_bad;
`endif
    endtask

    initial begin
        bus.SIN = 1'b0; bus.SIN_VALID = 1'b0; bus.SIN_FRAME = 1'b0; bus.PREADY = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_pdata",  32'(bus.PDATA), 32'h00);
        chk("rst_pvalid", 32'(bus.PVALID), 0);
        chk("rst_busy",   32'(bus.BUSY), 0);
        chk("rst_ferr",   32'(bus.FRAME_ERR), 0);
        chk("rst_ovr",    32'(bus.OVERRUN), 0);
`ifdef SIPO_PARITY_EN
        chk("rst_perr",   32'(bus.PERR), 0);
`endif
        RST = 1'b0;

        // Basic word
        clear_counts();
        send_word(8'hA5, 0, 1'b0, 1'b0);
        chk("basic_pvalid_early", 32'(bus.PVALID), 0);
        step();
        chk("basic_pdata",  32'(bus.PDATA), 32'hA5);
        chk("basic_pvalid", 32'(bus.PVALID), 1);
        chk("basic_busy",   32'(bus.BUSY), 0);
        step();
        chk("basic_drain",  32'(bus.PVALID), 0);
        chk("basic_ferr_cnt", 32'(ferr_cnt), 0);
        chk("basic_ovr_cnt",  32'(ovr_cnt), 0);

        // Stall tolerance
        busy_bad = 1'b0;
        send_word(8'hA5, 5, 1'b0, 1'b0);
        step();
        chk("stall_pdata",  32'(bus.PDATA), 32'hA5);
        chk("stall_pvalid", 32'(bus.PVALID), 1);
        chk("stall_busy_held", 32'(busy_bad), 0);
        step();

        // Framing abort
        clear_counts();
        send_bits(8'hE0, 3);
        send_word(8'h3C, 0, 1'b0, 1'b0);
        step(); step(); step();
        chk("abort_ferr_cnt",  32'(ferr_cnt), 1);
        chk("abort_deliv_cnt", 32'(deliv_cnt), 1);
        chk("abort_word",      32'(last_word), 32'h3C);

        // Overrun
        idle_ready = 1'b0;
        clear_counts();
        send_word(8'h11, 0, 1'b0, 1'b0);
        step();
        send_word(8'h22, 0, 1'b0, 1'b0);
        step();
        chk("ovr_pulse",  32'(bus.OVERRUN), 1);
        chk("ovr_pdata",  32'(bus.PDATA), 32'h11);
        chk("ovr_pvalid", 32'(bus.PVALID), 1);
        step();
        chk("ovr_pulse_end", 32'(bus.OVERRUN), 0);
        chk("ovr_cnt",       32'(ovr_cnt), 1);
        idle_ready = 1'b1; step();
        idle_ready = 1'b0; step();
        chk("ovr_drain_pvalid", 32'(bus.PVALID), 0);
        chk("ovr_drain_pdata",  32'(bus.PDATA), 32'h11);

        // Simultaneous accept and complete
        clear_counts();
        send_word(8'h11, 0, 1'b0, 1'b0);
        step();
        chk("sim_first_pvalid", 32'(bus.PVALID), 1);
        send_word(8'h22, 0, 1'b1, 1'b0);
        step();
        chk("sim_pdata",  32'(bus.PDATA), 32'h22);
        chk("sim_pvalid", 32'(bus.PVALID), 1);
        chk("sim_ovr_cnt", 32'(ovr_cnt), 0);
        chk("sim_deliv_11", 32'(last_word), 32'h11);
        idle_ready = 1'b1;
        step(); step();

        // Back-to-back words
        clear_counts();
        send_word(8'h3C, 0, 1'b0, 1'b0);
        send_word(8'hA5, 0, 1'b0, 1'b0);
        step(); step(); step();
        chk("b2b_deliv_cnt", 32'(deliv_cnt), 2);
        chk("b2b_last_word", 32'(last_word), 32'hA5);
        chk("b2b_ferr_cnt",  32'(ferr_cnt), 0);

        // Reset mid-word
        send_word(8'h5A, 0, 1'b0, 1'b0);
        idle_ready = 1'b0;
        step();
        send_bits(8'hA5, 4);
        @(negedge CLK);
        RST = 1'b1; bus.SIN_VALID = 1'b0; bus.SIN_FRAME = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk("mrst_pdata",  32'(bus.PDATA), 0);
        chk("mrst_pvalid", 32'(bus.PVALID), 0);
        chk("mrst_busy",   32'(bus.BUSY), 0);
        idle_ready = 1'b1;
        send_word(8'hA5, 0, 1'b0, 1'b0);
        step();
        chk("mrst_fresh_pdata",  32'(bus.PDATA), 32'hA5);
        chk("mrst_fresh_pvalid", 32'(bus.PVALID), 1);
`ifdef SIPO_PARITY_EN
        chk("par_ok_perr", 32'(bus.PERR), 0);
        step();
        send_word(8'hA5, 0, 1'b0, 1'b1);
        step();
        chk("par_bad_pdata", 32'(bus.PDATA), 32'hA5);
        chk("par_bad_perr",  32'(bus.PERR), 1);
`endif
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
